// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares one data-memory port between core and DMA requesters
// Optional stall statistics outputs are enabled with macro ARB_STATS_EN.
module dmem_port_arbiter #(
   parameter int WIDTH    = 32,
   parameter int MAX_WAIT = 4,
   parameter int MAX_LOCK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             core_req,
   input  logic             core_we,
   input  logic [WIDTH-1:0] core_addr,
   input  logic [WIDTH-1:0] core_wdata,
   output logic             core_gnt,
   output logic [WIDTH-1:0] core_rdata,
   input  logic             dma_req,
   input  logic             dma_we,
   input  logic             dma_lock,
   input  logic [WIDTH-1:0] dma_addr,
   input  logic [WIDTH-1:0] dma_wdata,
   output logic             dma_gnt,
   output logic [WIDTH-1:0] dma_rdata,
   output logic [WIDTH-1:0] mem_A,
   output logic [WIDTH-1:0] mem_WD,
   output logic             mem_WE,
   input  logic [WIDTH-1:0] mem_RD
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]      core_stall_cnt,
   output logic [15:0]      dma_stall_cnt
`endif
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int LW = $clog2(MAX_LOCK + 1);

   logic [WW-1:0] wait_cnt_q, wait_cnt_d;
   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   logic          locked_q, locked_d;

   // Grants are forced low while rst is asserted so no write can slip through.
   always_comb begin
      core_gnt = 1'b0;
      dma_gnt  = 1'b0;
      if (rst) begin
         if (locked_q && dma_req && dma_lock && (lock_cnt_q < LW'(MAX_LOCK)))
            dma_gnt = 1'b1;
         else if (dma_req && (wait_cnt_q == WW'(MAX_WAIT)))
            dma_gnt = 1'b1;
         else if (core_req)
            core_gnt = 1'b1;
         else if (dma_req)
            dma_gnt = 1'b1;
      end
   end

   always_comb begin
      mem_A  = '0;
      mem_WD = '0;
      mem_WE = 1'b0;
      if (core_gnt) begin
         mem_A  = core_addr;
         mem_WD = core_wdata;
         mem_WE = core_we;
      end else if (dma_gnt) begin
         mem_A  = dma_addr;
         mem_WD = dma_wdata;
         mem_WE = dma_we;
      end
   end

   assign core_rdata = mem_RD;
   assign dma_rdata  = mem_RD;

   always_comb begin
      wait_cnt_d = '0;
      if (dma_req && !dma_gnt)
         wait_cnt_d = (wait_cnt_q == WW'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 1'b1;

      locked_d   = 1'b0;
      lock_cnt_d = '0;
      // Lock count saturates so an unlocked rule-4 continuation holds it at MAX_LOCK.
      if (dma_gnt && dma_lock) begin
         locked_d   = 1'b1;
         lock_cnt_d = (lock_cnt_q == LW'(MAX_LOCK)) ? lock_cnt_q : lock_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt_q <= '0;
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
      end
   end

`ifdef ARB_STATS_EN
   logic [15:0] core_stall_cnt_q, core_stall_cnt_d;
   logic [15:0] dma_stall_cnt_q, dma_stall_cnt_d;

   always_comb begin
      core_stall_cnt_d = core_stall_cnt_q;
      dma_stall_cnt_d  = dma_stall_cnt_q;
      if (core_req && !core_gnt && (core_stall_cnt_q != 16'hFFFF))
         core_stall_cnt_d = core_stall_cnt_q + 16'd1;
      if (dma_req && !dma_gnt && (dma_stall_cnt_q != 16'hFFFF))
         dma_stall_cnt_d = dma_stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         core_stall_cnt_q <= '0;
         dma_stall_cnt_q  <= '0;
      end else begin
         core_stall_cnt_q <= core_stall_cnt_d;
         dma_stall_cnt_q  <= dma_stall_cnt_d;
      end
   end

   assign core_stall_cnt = core_stall_cnt_q;
   assign dma_stall_cnt  = dma_stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req, core_we;
   logic [31:0] core_addr, core_wdata, core_rdata;
   logic        core_gnt;
   logic        dma_req, dma_we, dma_lock;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic        dma_gnt;
   logic [31:0] mem_A, mem_WD, mem_RD;
   logic        mem_WE;
`ifdef ARB_STATS_EN
   logic [15:0] core_stall_cnt, dma_stall_cnt;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] mem [0:63];

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_WE) mem[mem_A[7:2]] <= mem_WD;
   assign mem_RD = mem[mem_A[7:2]];

   dmem_port_arbiter #(.WIDTH(32), .MAX_WAIT(4), .MAX_LOCK(8)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rdata(core_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
      .dma_rdata(dma_rdata),
      .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
`ifdef ARB_STATS_EN
      , .core_stall_cnt(core_stall_cnt), .dma_stall_cnt(dma_stall_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      rst = 1'b0;
      core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
      dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0;

      // reset state, with a core request pending
      @(negedge clk);
      core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'h5555_5555;
      #1;
      chk("rst_core_gnt", {31'b0, core_gnt}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_WE}, 32'd0);
      chk("rst_mem_a", mem_A, 32'h0);
      @(negedge clk);
      core_req = 0; core_we = 0;
      rst = 1'b1;

      // test 1: core store then load
      @(negedge clk);
      core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF;
      #1;
      chk("t1_core_gnt", {31'b0, core_gnt}, 32'd1);
      chk("t1_mem_we", {31'b0, mem_WE}, 32'd1);
      chk("t1_mem_a", mem_A, 32'h10);
      chk("t1_mem_wd", mem_WD, 32'hDEADBEEF);
      @(negedge clk);
      core_we = 0;
      #1;
      chk("t1_core_rdata", core_rdata, 32'hDEADBEEF);
      chk("t1_load_we", {31'b0, mem_WE}, 32'd0);

      // test 5: idle, then DMA write with core idle
      @(negedge clk);
      core_req = 0;
      #1;
      chk("t5_idle_gnt", {30'b0, core_gnt, dma_gnt}, 32'd0);
      chk("t5_idle_we", {31'b0, mem_WE}, 32'd0);
      chk("t5_idle_a", mem_A, 32'h0);
      chk("t5_idle_wd", mem_WD, 32'h0);
      @(negedge clk);
      dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h1234_5678;
      #1;
      chk("t5_dma_gnt", {30'b0, core_gnt, dma_gnt}, 32'd1);
      chk("t5_dma_we", {31'b0, mem_WE}, 32'd1);
      chk("t5_dma_a", mem_A, 32'h20);
      @(negedge clk);
      dma_we = 0;
      #1;
      chk("t5_dma_rdata", dma_rdata, 32'h1234_5678);
      @(negedge clk);
      dma_req = 0;

      // test 2: both requesting, pattern core x4 then DMA, 20 cycles
      @(negedge clk);
      core_req = 1; core_we = 0; core_addr = 32'h40;
      dma_req = 1; dma_we = 0; dma_lock = 0; dma_addr = 32'h80;
      for (int i = 1; i <= 20; i++) begin
         #1;
         chk($sformatf("t2_gnt_c%0d", i), {30'b0, core_gnt, dma_gnt},
             (i % 5 == 0) ? 32'd1 : 32'd2);
         chk($sformatf("t2_mem_a_c%0d", i), mem_A, (i % 5 == 0) ? 32'h80 : 32'h40);
         @(negedge clk);
      end
`ifdef ARB_STATS_EN
      chk("t6_dma_stall", {16'b0, dma_stall_cnt}, 32'd16);
      chk("t6_core_stall", {16'b0, core_stall_cnt}, 32'd4);
`endif

      // test 3: lock burst entered via forced grant; 4 core, 8 DMA, then core
      dma_lock = 1;
      for (int i = 1; i <= 16; i++) begin
         #1;
         chk($sformatf("t3_gnt_c%0d", i), {30'b0, core_gnt, dma_gnt},
             (i >= 5 && i <= 12) ? 32'd1 : 32'd2);
         @(negedge clk);
      end

      // test 4: forced DMA grant starts a new lock, then reset mid-burst
      #1;
      chk("t4_forced", {30'b0, core_gnt, dma_gnt}, 32'd1);
      @(negedge clk);
      #1;
      chk("t4_locked", {30'b0, core_gnt, dma_gnt}, 32'd1);
      @(negedge clk);
      dma_we = 1; dma_wdata = 32'hBAD0_BAD0;
      #1;
      chk("t4_pre_rst_we", {31'b0, mem_WE}, 32'd1);
      #1;
      rst = 1'b0;
      #1;
      chk("t4_rst_gnt", {30'b0, core_gnt, dma_gnt}, 32'd0);
      chk("t4_rst_we", {31'b0, mem_WE}, 32'd0);
      chk("t4_rst_a", mem_A, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      dma_we = 0;
      core_addr = 32'h80;
      #1;
      chk("t4_post_core_gnt", {30'b0, core_gnt, dma_gnt}, 32'd2);
      chk("t4_no_write", core_rdata, 32'h0);
      @(negedge clk);
      core_req = 0; dma_req = 0; dma_lock = 0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
